aurora_hls_nfc: RTL and testbench
=================================

AURORA_HLS_NFC -- requirements
Module: aurora_hls_nfc

Interface
REQ-001 SHALL have parameter XOFF_WORD, default 16'h0100, which is the NFC word requesting the link partner to stop sending (pause count 0, XOFF bit set).
REQ-002 SHALL have parameter XON_WORD, default 16'h0000, which is the NFC word requesting the link partner to resume sending.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high (the port name is kept as-is despite the _n suffix).
REQ-005 SHALL have port fifo_rx_prog_full, input, 1 bit: RX FIFO is above its high watermark.
REQ-006 SHALL have port fifo_rx_prog_empty, input, 1 bit: RX FIFO is below its low watermark.
REQ-007 SHALL have port s_axi_nfc_tready, input, 1 bit: the Aurora core accepts the NFC word.
REQ-008 SHALL have port s_axi_nfc_tvalid, output, 1 bit: an NFC word is presented.
REQ-009 SHALL have port s_axi_nfc_tdata, output, 16 bits: the NFC word.

Function
REQ-010 SHALL implement a 4-state FSM: ON (partner sending), SEND_XOFF, OFF (partner paused), SEND_XON.
REQ-011 In ON, with fifo_rx_prog_full=1 sampled at edge N, SHALL enter SEND_XOFF, with tvalid=1 and tdata=XOFF_WORD visible after edge N (1-cycle latency).
REQ-012 In SEND_XOFF, tvalid and tdata SHALL hold stable until a cycle where tvalid=1 and tready=1; at that edge SHALL go to OFF with tvalid=0 after the edge.
REQ-013 In OFF, with fifo_rx_prog_empty=1 and fifo_rx_prog_full=0, SHALL enter SEND_XON, with tvalid=1 and tdata=XON_WORD after the edge.
REQ-014 In SEND_XON, outputs SHALL hold stable until handshake; then SHALL go to ON with tvalid=0.
REQ-015 Hysteresis: in OFF with both flags 0, SHALL stay in OFF; in ON, fifo_rx_prog_empty SHALL be ignored.
REQ-016 Both flags 1 simultaneously: prog_full SHALL win, so the block enters or stays in the paused path and never starts XON.
REQ-017 Flag changes during SEND_XOFF/SEND_XON SHALL NOT alter or withdraw the pending word (AXI-Stream stability); re-evaluation SHALL happen only after the handshake.
REQ-018 prog_full still 1 when XOFF completes: SHALL stay in OFF with no repeated XOFF.
REQ-019 prog_full re-asserted right after XON completes: SHALL start a new XOFF in the next cycle.
REQ-020 tdata SHALL be a don't-care while tvalid=0 but SHALL be driven to XON_WORD (16'h0000) in ON/OFF.
REQ-021 All outputs SHALL be registered; no combinational path SHALL exist from inputs to outputs.
REQ-022 tready=1 while tvalid=0 SHALL have no effect.

Reset
REQ-023 With rst_n=1 at a rising edge, SHALL force state ON, s_axi_nfc_tvalid=0, and s_axi_nfc_tdata=16'h0000 after that edge.
REQ-024 Reset mid-handshake, in any state, SHALL abort the pending word immediately, with no completion after release.
REQ-025 After reset release, SHALL resume normal evaluation on the first edge with rst_n=0.

Verification
REQ-026 Scenario: reset, then prog_full=1 with tready=0 for 5 cycles -> tvalid=1 and tdata=16'h0100 held constant for all 5 cycles.
REQ-027 Scenario: continuing, tready=1 -> exactly one handshake, then tvalid=0 while prog_full stays 1 for 20 cycles.
REQ-028 Scenario: prog_full=0, then prog_empty=1 with tready=1 -> one cycle of tvalid=1 with tdata=16'h0000, then tvalid=0, with no further words while prog_empty=1 for 20 cycles.
REQ-029 Scenario: in OFF, both flags 0 for 10 cycles -> tvalid stays 0; then both flags 1 -> no XON is issued.
REQ-030 Scenario: prog_full pulse for 1 cycle in ON with tready=0, deasserted, then prog_empty=1 -> XOFF held until tready=1, and only then XON is issued.
REQ-031 Scenario: rst_n=1 asserted while XOFF is pending (tvalid=1, tready=0) -> tvalid=0 and tdata=16'h0000 on the next cycle, state ON.

Source files
------------

// File: rtl/aurora_hls_nfc.sv
// Native flow control generator for an Aurora RX path: issues XOFF when the RX FIFO
// crosses its high watermark and XON once it drains below its low watermark.
module aurora_hls_nfc #(
  parameter logic [15:0] XOFF_WORD = 16'h0100,
  parameter logic [15:0] XON_WORD  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_rx_prog_full,
  input  logic        fifo_rx_prog_empty,
  input  logic        s_axi_nfc_tready,
  output logic        s_axi_nfc_tvalid,
  output logic [15:0] s_axi_nfc_tdata
);

  typedef enum logic [1:0] {
    StOn      = 2'd0,
    StSendXoff = 2'd1,
    StOff     = 2'd2,
    StSendXon = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        tvalid_q, tvalid_d;
  logic [15:0] tdata_q, tdata_d;
  logic        handshake;

  assign handshake = tvalid_q & s_axi_nfc_tready;

  // Pending words are never withdrawn; flags are only re-evaluated in ON/OFF.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOn: begin
        if (fifo_rx_prog_full) state_d = StSendXoff;
      end
      StSendXoff: begin
        if (handshake) state_d = StOff;
      end
      StOff: begin
        // prog_full dominates so simultaneous flags never trigger XON
        if (fifo_rx_prog_empty && !fifo_rx_prog_full) state_d = StSendXon;
      end
      StSendXon: begin
        if (handshake) state_d = StOn;
      end
      default: state_d = StOn;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    tvalid_d = 1'b0;
    tdata_d  = XON_WORD;
    unique case (state_d)
      StSendXoff: begin
        tvalid_d = 1'b1;
        tdata_d  = XOFF_WORD;
      end
      StSendXon: begin
        tvalid_d = 1'b1;
        tdata_d  = XON_WORD;
      end
      default: begin
        tvalid_d = 1'b0;
        tdata_d  = XON_WORD;
      end
    endcase
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= StOn;
      tvalid_q <= 1'b0;
      tdata_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  assign s_axi_nfc_tvalid = tvalid_q;
  assign s_axi_nfc_tdata  = tdata_q;

endmodule

// File: tb/tb_aurora_hls_nfc.sv
// Directed bench for aurora_hls_nfc: expected outputs are queued as each step is driven
// and compared one cycle later; completed handshakes are tallied independently.
module tb_aurora_hls_nfc;

  logic        clk;
  logic        rst_n;
  logic        prog_full;
  logic        prog_empty;
  logic        tready;
  logic        tvalid;
  logic [15:0] tdata;

  typedef struct {
    logic        v;
    logic [15:0] d;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_err;
  int   hs_count;

  aurora_hls_nfc #(
    .XOFF_WORD(16'h0100),
    .XON_WORD (16'h0000)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fifo_rx_prog_full (prog_full),
    .fifo_rx_prog_empty(prog_empty),
    .s_axi_nfc_tready  (tready),
    .s_axi_nfc_tvalid  (tvalid),
    .s_axi_nfc_tdata   (tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n && tvalid && tready) hs_count <= hs_count + 1;
  end

  // Drive one cycle of inputs, queue the output expected after the next edge, then check it.
  task automatic step(input logic r, input logic f, input logic e, input logic rdy,
                      input logic ev, input logic [15:0] ed, input string tag);
    exp_t x;
    exp_t got;
    rst_n      = r;
    prog_full  = f;
    prog_empty = e;
    tready     = rdy;
    x.v   = ev;
    x.d   = ed;
    x.tag = tag;
    q.push_back(x);
    @(posedge clk);
    #1;
    got = q.pop_front();
    n_vec++;
    assert ({tvalid, tdata} === {got.v, got.d}) else begin
      n_err++;
      $error("FAIL %s: tvalid/tdata got %b/%h expected %b/%h",
             got.tag, tvalid, tdata, got.v, got.d);
    end
  endtask

  task automatic check_hs(input int expected, input string tag);
    n_vec++;
    assert (hs_count === expected) else begin
      n_err++;
      $error("FAIL %s: handshakes got %0d expected %0d", tag, hs_count, expected);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    hs_count = 0;
    rst_n = 1'b1;
    prog_full = 1'b0;
    prog_empty = 1'b0;
    tready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    step(1, 0, 0, 0, 0, 16'h0000, "reset0");
    step(1, 0, 0, 1, 0, 16'h0000, "reset1");

    // XOFF requested and held while tready=0
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 16'h0100, "xoff_hold");
    check_hs(0, "hs_none_yet");

    // One handshake, then silence while prog_full stays high
    step(0, 1, 0, 1, 0, 16'h0000, "xoff_done");
    for (int i = 0; i < 20; i++) step(0, 1, 0, 1, 0, 16'h0000, "off_full_no_repeat");
    check_hs(1, "hs_xoff_once");

    // Drain: XON for one cycle, then ON ignores prog_empty
    step(0, 0, 0, 1, 0, 16'h0000, "off_idle");
    step(0, 0, 1, 1, 1, 16'h0000, "xon_issue");
    step(0, 0, 1, 1, 0, 16'h0000, "xon_done");
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0, 16'h0000, "on_ignore_empty");
    check_hs(2, "hs_xon_once");

    // Back to OFF, then hysteresis and flag-priority checks
    step(0, 1, 0, 1, 1, 16'h0100, "xoff2_issue");
    step(0, 1, 0, 1, 0, 16'h0000, "xoff2_done");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 16'h0000, "off_hysteresis");
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0, 16'h0000, "both_flags_no_xon");
    check_hs(3, "hs_no_xon_both");

    // XON held across flag changes, then prog_full right after XON starts a new XOFF
    step(0, 0, 1, 0, 1, 16'h0000, "xon2_issue");
    step(0, 1, 1, 0, 1, 16'h0000, "xon2_stable");
    step(0, 1, 0, 1, 0, 16'h0000, "xon2_done");
    step(0, 1, 0, 0, 1, 16'h0100, "xoff_after_xon");

    // Pulse ended, prog_empty up: XOFF held until tready, only then XON
    step(0, 0, 1, 0, 1, 16'h0100, "xoff3_stable0");
    step(0, 0, 1, 0, 1, 16'h0100, "xoff3_stable1");
    step(0, 0, 1, 1, 0, 16'h0000, "xoff3_done");
    step(0, 0, 1, 1, 1, 16'h0000, "xon3_issue");
    step(0, 0, 0, 1, 0, 16'h0000, "xon3_done");
    check_hs(6, "hs_pulse_seq");

    // tready with tvalid low does nothing
    step(0, 0, 0, 1, 0, 16'h0000, "ready_idle");

    // Reset aborts a pending XOFF; afterwards the block is in ON
    step(0, 1, 0, 0, 1, 16'h0100, "xoff4_issue");
    step(1, 1, 0, 0, 0, 16'h0000, "reset_abort");
    step(0, 0, 0, 1, 0, 16'h0000, "post_reset_idle");
    check_hs(6, "hs_abort_no_complete");
    step(0, 1, 0, 0, 1, 16'h0100, "post_reset_on");

    // Reset out of OFF lands in ON, where prog_empty is ignored
    step(0, 1, 0, 1, 0, 16'h0000, "xoff5_done");
    step(1, 0, 1, 0, 0, 16'h0000, "reset_from_off");
    step(0, 0, 1, 0, 0, 16'h0000, "reset_off_to_on");
    check_hs(7, "hs_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
